// File: rtl/puf_measure_ctrl.sv
// Ring-oscillator PUF measurement sequencer: clears, gates and compares RO pairs to build a response word.
// Optional tie flag output enabled by defining PUF_TIE_FLAG_EN.
module puf_measure_ctrl #(
    parameter int unsigned RESP_W = 16,
    parameter int unsigned CNT_W  = 20,
    parameter int unsigned SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           window_cycles,
    input  logic [CNT_W-1:0]      cnt_a,
    input  logic [CNT_W-1:0]      cnt_b,
    output logic [((RESP_W > 1) ? $clog2(RESP_W) : 1)-1:0] ro_sel,
    output logic                  ro_clear,
    output logic                  ro_ce,
    output logic                  time_stop,
    output logic [RESP_W-1:0]     response,
`ifdef PUF_TIE_FLAG_EN
    output logic [RESP_W-1:0]     tie_mask,
`endif
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned SEL_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int unsigned TMR_W = 16;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(RESP_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_COUNT, S_SETTLE, S_COMPARE, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    win_q, win_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic [RESP_W-1:0]   tie_q, tie_d;
    logic                ro_clear_q, ro_ce_q, time_stop_q, busy_q, done_q;

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        tmr_d   = tmr_q;
        sel_d   = sel_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLEAR;
                    win_d   = window_cycles;
                    sel_d   = '0;
                    resp_d  = '0;
                    tie_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_COUNT;
                tmr_d   = (win_q == '0) ? '0 : win_q - TMR_W'(1);
            end
            S_COUNT: begin
                if (tmr_q == '0) begin
                    state_d = S_SETTLE;
                    tmr_d   = TMR_W'(SETTLE - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_SETTLE: begin
                if (tmr_q == '0) begin
                    state_d = S_COMPARE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_COMPARE: begin
                resp_d[sel_q] = (cnt_a > cnt_b);
                tie_d[sel_q]  = (cnt_a == cnt_b);
                if (sel_q == LAST_SEL) begin
                    state_d = S_DONE;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = S_CLEAR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            sel_d   = '0;
            resp_d  = '0;
            tie_d   = '0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            tmr_q       <= '0;
            sel_q       <= '0;
            resp_q      <= '0;
            tie_q       <= '0;
            ro_clear_q  <= 1'b0;
            ro_ce_q     <= 1'b0;
            time_stop_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            tmr_q       <= tmr_d;
            sel_q       <= sel_d;
            resp_q      <= resp_d;
            tie_q       <= tie_d;
            ro_clear_q  <= (state_d == S_CLEAR);
            ro_ce_q     <= (state_d == S_COUNT);
            time_stop_q <= (state_d == S_SETTLE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign ro_sel    = sel_q;
    assign ro_clear  = ro_clear_q;
    assign ro_ce     = ro_ce_q;
    assign time_stop = time_stop_q;
    assign response  = resp_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef PUF_TIE_FLAG_EN
    assign tie_mask = tie_q;
`else
    logic unused_tie;
    assign unused_tie = ^tie_q;
`endif

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Scoreboard bench for puf_measure_ctrl: runs push expected results, a negedge monitor checks each done pulse.
module tb_puf_measure_ctrl;

    localparam int unsigned RESP_W = 4;
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned SETTLE = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [15:0]       window_cycles;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    logic [1:0]        ro_sel;
    logic              ro_clear, ro_ce, time_stop, busy, done;
    logic [RESP_W-1:0] response;
`ifdef PUF_TIE_FLAG_EN
    logic [RESP_W-1:0] tie_mask;
`endif

    typedef struct {
        logic [3:0] resp;
        logic [3:0] tie;
        int         lat;
        int         ce;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] pa[4];
    logic [CNT_W-1:0] pb[4];
    int               total = 0;
    int               passed = 0;
    int               viol = 0;
    int               busy_cnt = 0;
    int               ce_cnt = 0;

    puf_measure_ctrl #(.RESP_W(RESP_W), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .window_cycles(window_cycles), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .ro_sel(ro_sel), .ro_clear(ro_clear), .ro_ce(ro_ce), .time_stop(time_stop),
        .response(response),
`ifdef PUF_TIE_FLAG_EN
        .tie_mask(tie_mask),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Pair mux model: counts of the currently selected RO pair.
    assign cnt_a = pa[ro_sel];
    assign cnt_b = pb[ro_sel];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_pat(input logic [3:0] gt, input logic [3:0] eq);
        for (int i = 0; i < 4; i++) begin
            if (eq[i]) begin
                pa[i] = 20'h00100; pb[i] = 20'h00100;
            end else if (gt[i]) begin
                pa[i] = 20'd200 + 20'(i); pb[i] = 20'd100;
            end else begin
                pa[i] = 20'd100; pb[i] = 20'd150 + 20'(i);
            end
        end
    endtask

    task automatic push(input logic [3:0] r, input logic [3:0] t, input int w);
        exp_t e;
        int   we;
        we = (w == 0) ? 1 : w;
        e.resp = r;
        e.tie  = t;
        e.lat  = 4 * (2 + we + 4) + 1;
        e.ce   = 4 * we;
        sb.push_back(e);
    endtask

    task automatic do_start(input int w);
        window_cycles = 16'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(nm, 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_for(input int which, input string nm);
        int  i;
        bit  hit;
        hit = 1'b0;
        for (i = 0; i < 200; i++) begin
            if ((which == 0 && ro_sel == 2'd1 && ro_ce) ||
                (which == 1 && time_stop) ||
                (which == 2 && ro_ce)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(nm, 32'(hit), 32'd1);
    endtask

    // Monitor: invariants every cycle, scoreboard comparison on each done pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            ce_cnt   = 0;
        end else begin
            if (ro_ce && time_stop) viol++;
            if (!busy && (ro_ce || time_stop || done)) viol++;
            if (!busy) begin
                busy_cnt = 0;
                ce_cnt   = 0;
            end else begin
                busy_cnt++;
                if (ro_ce) ce_cnt++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("response", 32'(response), 32'(e.resp));
                    check("done_latency", 32'(busy_cnt), 32'(e.lat));
                    check("ro_ce_cycles", 32'(ce_cnt), 32'(e.ce));
`ifdef PUF_TIE_FLAG_EN
                    check("tie_mask", 32'(tie_mask), 32'(e.tie));
`endif
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; window_cycles = 16'd0;
        set_pat(4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        check("rst_outputs", {26'd0, ro_sel, ro_clear, ro_ce, time_stop, busy, done}, 32'd0);
        check("rst_response", 32'(response), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Pairs 0 and 2 win, window 10.
        set_pat(4'b0101, 4'b0000);
        push(4'b0101, 4'b0000, 10);
        do_start(10);
        check("clear_first", {30'd0, ro_clear, ro_sel == 2'd0}, 32'd3);
        drain("run_w10");
        check("resp_hold", 32'(response), 32'h5);

        // Zero window counts as one cycle per pair.
        set_pat(4'b1010, 4'b0000);
        push(4'b1010, 4'b0000, 0);
        do_start(0);
        drain("run_w0");

        // Start during COUNT must not perturb the run.
        set_pat(4'b0110, 4'b0000);
        push(4'b0110, 4'b0000, 5);
        do_start(5);
        wait_for(2, "reach_count");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("run_restart_ignored");

        // Start with abort in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // Abort during COUNT of pair 1.
        set_pat(4'b0001, 4'b0000);
        do_start(10);
        wait_for(0, "reach_pair1_count");
        check("resp_before_abort", 32'(response), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", {26'd0, ro_sel, ro_clear, ro_ce, time_stop, busy, done}, 32'd0);
        check("abort_response", 32'(response), 32'd0);
        repeat (80) @(negedge clk);

        // Reset during SETTLE, then a fresh run with a tie on pair 3.
        set_pat(4'b0001, 4'b1000);
        do_start(10);
        wait_for(1, "reach_settle");
        rst = 1'b1;
        #1;
        check("midrun_rst_outputs", {26'd0, ro_sel, ro_clear, ro_ce, time_stop, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(4'b0001, 4'b1000, 3);
        do_start(3);
        check("fresh_run_pair0", {30'd0, ro_clear, ro_sel == 2'd0}, 32'd3);
        drain("run_after_rst");

        check("ce_ts_invariant", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/puf_measure_ctrl.md
PUF_MEASURE_CTRL -- requirements
Module: puf_measure_ctrl

Interface
REQ-001 Parameter RESP_W, default 16: number of response bits, which equals the number of RO pairs measured per run.
REQ-002 Parameter CNT_W, default 20: width of each RO pair counter value.
REQ-003 Parameter SETTLE, default 4: number of cycles to wait after the window closes before the counts are compared; legal range is 1..255.
REQ-004 Port list: clk in 1, the single system clock. All logic is in this clock domain.
REQ-005 Port: rst in 1, asynchronous, active-high reset.
REQ-006 Port: start in 1, single-cycle request to begin a measurement run.
REQ-007 Port: abort in 1, ends the current run immediately.
REQ-008 Port: window_cycles in 16, count window length in clk cycles.
REQ-009 Port: cnt_a in CNT_W, count from ring oscillator A of the selected pair.
REQ-010 Port: cnt_b in CNT_W, count from ring oscillator B of the selected pair.
REQ-011 Port: ro_sel out clog2(RESP_W), index of the selected RO pair, driving the pair mux.
REQ-012 Port: ro_clear out 1, clears both RO counters.
REQ-013 Port: ro_ce out 1, count enable, driving the CE input of the timer gate.
REQ-014 Port: time_stop out 1, stop request to the timer gate.
REQ-015 Port: response out RESP_W, assembled PUF response.
REQ-016 Port: busy out 1, high while a run is in progress.
REQ-017 Port: done out 1, single-cycle run-complete pulse.

Function
REQ-018 The FSM states are IDLE, CLEAR, COUNT, SETTLE, COMPARE and DONE. All outputs are registered.
REQ-019 IDLE, start=1: go to CLEAR on the next cycle, latch window_cycles, set ro_sel=0, clear response.
- start is ignored in every state other than IDLE.
REQ-020 CLEAR: ro_clear=1 for exactly one cycle, then go to COUNT.
REQ-021 COUNT: ro_ce=1 and time_stop=0 for exactly max(latched window,1) cycles, then go to SETTLE.
- A latched window of 0 is treated as 1.
REQ-022 SETTLE: ro_ce=0 and time_stop=1 for exactly SETTLE cycles, then go to COMPARE.
REQ-023 COMPARE: for one cycle, response[ro_sel] = (cnt_a > cnt_b), unsigned.
- Equal counts give 0.
REQ-024 After COMPARE:
- If ro_sel == RESP_W-1, go to DONE.
- Otherwise increment ro_sel and go to CLEAR.
REQ-025 DONE: done=1 for one cycle, then go to IDLE.
- response holds its value until the next accepted start.
REQ-026 Each response bit takes 2 + W + SETTLE cycles.
- W is the effective window from REQ-021.
- done asserts RESP_W*(2+W+SETTLE)+1 cycles after the start cycle.
REQ-027 busy=1 in every state except IDLE.
REQ-028 abort=1 in any non-IDLE state: next cycle is IDLE, with ro_ce=0, time_stop=0, response cleared and no done pulse.
- abort has priority over every other transition.
REQ-029 start and abort asserted together in IDLE: abort wins and the FSM stays in IDLE.
REQ-030 ro_ce and time_stop are never high in the same cycle. time_stop=0 in IDLE.

Reset
REQ-031 While rst=1, the block forces IDLE: ro_sel=0, ro_clear=0, ro_ce=0, time_stop=0, response=0, busy=0, done=0.
REQ-032 Reset asserted mid-run discards the run with no done pulse. The first start after rst deasserts begins a fresh run.

Configuration
REQ-033 Macro PUF_TIE_FLAG_EN, when defined, adds output tie_mask out RESP_W.
- tie_mask[ro_sel] is set in COMPARE when cnt_a == cnt_b.
- tie_mask is cleared on start, on abort and on reset.
REQ-034 Without PUF_TIE_FLAG_EN, the tie_mask port and its logic are absent, and all other behaviour is identical.

Verification
REQ-035 RESP_W=4, SETTLE=4, window=10, start pulse, with cnt_a>cnt_b on pairs 0 and 2 only -> response=4'b0101, done exactly 65 cycles after start, busy high throughout.
REQ-036 window_cycles=0 -> ro_ce high for exactly 1 cycle per pair.
REQ-037 abort asserted during COUNT of pair 1 -> IDLE next cycle, response=0, no done pulse, and ro_ce=0 with time_stop=0 within 1 cycle.
REQ-038 rst asserted during SETTLE, then released, then start -> the run begins at pair 0 and completes normally.
REQ-039 cnt_a==cnt_b=20'h00100 on pair 3 -> response[3]=0; with PUF_TIE_FLAG_EN defined, tie_mask=4'b1000.
REQ-040 start pulsed during COUNT -> ignored, with unchanged timing. On every cycle, ro_ce and time_stop are never both high.
